// File: rtl/approx_mult_error_monitor_if.sv
// Sample stream between the multiplier under test and the error monitor.
// Handshake: a sample (x, y, z) transfers on a rising clk edge where
// in_valid && in_ready are both high; the source holds x/y/z stable while
// in_valid is high, and in_ready never depends combinationally on in_valid.
interface approx_mult_error_monitor_if #(
   parameter int W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     x;
   logic [W-1:0]     y;
   logic [2*W-1:0]   z;

   modport master (output in_valid, output x, output y, output z, input in_ready);
   modport slave  (input in_valid, input x, input y, input z, output in_ready);
endinterface

// File: rtl/approx_mult_error_monitor.sv
// Error-statistics monitor for an 8x8 approximate multiplier. Each accepted
// sample is compared against the exact product in a 2-stage pipeline and
// folded into count / error count / max error / saturating abs-error sum.
module approx_mult_error_monitor #(
   parameter int W     = 8,
   parameter int CNT_W = 16,
   parameter int ACC_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [CNT_W-1:0]     num_samples,
   approx_mult_error_monitor_if.slave s_if,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     sample_count,
   output logic [CNT_W-1:0]     err_count,
   output logic [2*W-1:0]       max_err,
   output logic [ACC_W-1:0]     sum_abs_err,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_num;
   logic [CNT_W-1:0]  r_accepted;
   logic              r_zero_pass;   // forces done low for the cycle after a zero-length start

   logic [W-1:0]      r_s1_x;
   logic [W-1:0]      r_s1_y;
   logic [2*W-1:0]    r_s1_z;
   logic              r_s1_valid;
   logic [2*W-1:0]    r_s2_diff;
   logic              r_s2_neq;
   logic              r_s2_valid;

   logic [CNT_W-1:0]  r_sample_count;
   logic [CNT_W-1:0]  r_err_count;
   logic [2*W-1:0]    r_max_err;
   logic [ACC_W-1:0]  r_sum;

   logic              w_start_ok;
   logic              w_more;
   logic              w_xfer;
   logic [CNT_W-1:0]  w_acc_inc;
   logic [2*W-1:0]    w_exact;
   logic signed [2*W:0] w_diff_s;
   logic signed [2*W:0] w_diff_neg;
   logic [2*W-1:0]    w_diff;
   logic [ACC_W:0]    w_sum_ext;

   assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_more     = (r_accepted < r_num);
   assign w_xfer     = s_if.in_valid && s_if.in_ready;
   assign w_acc_inc  = r_accepted + CNT_W'(1);

   // Exact product and signed difference; magnitude always fits 2W bits.
   assign w_exact    = {{W{1'b0}}, r_s1_x} * {{W{1'b0}}, r_s1_y};
   assign w_diff_s   = $signed({1'b0, r_s1_z}) - $signed({1'b0, w_exact});
   assign w_diff_neg = -w_diff_s;
   assign w_diff     = w_diff_s[2*W] ? w_diff_neg[2*W-1:0] : w_diff_s[2*W-1:0];

   // One spare bit catches the carry that signals accumulator overflow.
   assign w_sum_ext  = {1'b0, r_sum} + {{(ACC_W+1-2*W){1'b0}}, r_s2_diff};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic; start is only honoured from IDLE or DONE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (w_start_ok) w_next = (num_samples == '0) ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            if (w_xfer && (w_acc_inc == r_num)) w_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!r_s1_valid && !r_s2_valid) w_next = ST_DONE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Outputs decoded from registered state only.
   always_comb begin
      s_if.in_ready = (r_state == ST_RUN) && w_more;
      busy          = (r_state == ST_RUN) || (r_state == ST_DRAIN);
      done          = (r_state == ST_DONE) && !r_zero_pass;
      dbg_state     = r_state;
   end

   // Run bookkeeping: latched length, accepted counter, zero-run marker.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_num       <= '0;
         r_accepted  <= '0;
         r_zero_pass <= 1'b0;
      end else begin
         r_zero_pass <= w_start_ok && (num_samples == '0);
         if (w_start_ok) begin
            r_num      <= num_samples;
            r_accepted <= '0;
         end else if (w_xfer) begin
            r_accepted <= w_acc_inc;
         end
      end
   end

   // Pipeline: S1 captures the transfer, S2 holds |z - x*y| and its nonzero flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_x     <= '0;
         r_s1_y     <= '0;
         r_s1_z     <= '0;
         r_s1_valid <= 1'b0;
         r_s2_diff  <= '0;
         r_s2_neq   <= 1'b0;
         r_s2_valid <= 1'b0;
      end else begin
         r_s1_valid <= w_xfer && !w_start_ok;
         if (w_xfer) begin
            r_s1_x <= s_if.x;
            r_s1_y <= s_if.y;
            r_s1_z <= s_if.z;
         end
         r_s2_valid <= r_s1_valid && !w_start_ok;
         r_s2_diff  <= w_diff;
         r_s2_neq   <= (w_diff != '0);
      end
   end

   // Statistics accumulators; cleared on the edge that accepts a start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sample_count <= '0;
         r_err_count    <= '0;
         r_max_err      <= '0;
         r_sum          <= '0;
      end else if (w_start_ok) begin
         r_sample_count <= '0;
         r_err_count    <= '0;
         r_max_err      <= '0;
         r_sum          <= '0;
      end else if (r_s2_valid) begin
         r_sample_count <= r_sample_count + CNT_W'(1);
         r_err_count    <= r_err_count + CNT_W'(r_s2_neq);
         if (r_s2_diff > r_max_err) r_max_err <= r_s2_diff;
         r_sum          <= w_sum_ext[ACC_W] ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
      end
   end

   assign sample_count = r_sample_count;
   assign err_count    = r_err_count;
   assign max_err      = r_max_err;
   assign sum_abs_err  = r_sum;

endmodule
